offset_add_arbiter: RTL and testbench
=====================================

Name: offset_add_arbiter

Overview:
Shares one registered offset-adder stage between two requesters, A and B.
- Each requester offers a WIDTH-bit operand over a valid/ready handshake.
- The block arbitrates round-robin and adds the winner's fixed offset (OFFSET_A or OFFSET_B).
- The result is presented one cycle later on a valid/ready output tagged with its source.
- It sits between the counter datapath and downstream consumers, replacing per-requester adder instances.

Parameters:
WIDTH, 32, operand/result width
OFFSET_A, 2, constant added to requester A operands
OFFSET_B, 5, constant added to requester B operands
CNT_W, 16, width of per-requester grant counters

Ports:
clk  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-low reset
a_valid  in  1  requester A operand valid
a_data  in  WIDTH  requester A operand
a_ready  out  1  A operand accepted this cycle when a_valid & a_ready
b_valid  in  1  requester B operand valid
b_data  in  WIDTH  requester B operand
b_ready  out  1  B operand accepted this cycle when b_valid & b_ready
out_valid  out  1  result valid
out_data  out  WIDTH  operand + offset, modulo 2^WIDTH
out_src  out  1  0 = result from A, 1 = from B
out_ready  in  1  downstream accepts result when out_valid & out_ready
grant_cnt_a  out  CNT_W  number of A operands accepted, wraps
grant_cnt_b  out  CNT_W  number of B operands accepted, wraps

Behaviour:
- Reset (reset low, asynchronous):
  - out_valid=0, out_data=0, out_src=0.
  - grant_cnt_a=0, grant_cnt_b=0.
  - Priority pointer prio=A.
  - Outputs hold these values while reset is low.
- can_accept = ~out_valid | out_ready. The single output register is either empty or being drained this cycle, giving full throughput with no bubble.
- Ready generation (combinational, never depends on own valid):
  - a_ready = can_accept & (~b_valid | prio==A)
  - b_ready = can_accept & (~a_valid | prio==B)
  - At most one handshake completes per cycle. When both are valid, only the prio side sees ready.
- On accept from X (X in {A,B}), at the next rising edge:
  - out_data <= X_data + OFFSET_X, truncated to WIDTH (wraps, no carry out).
  - out_src <= X; out_valid <= 1.
  - grant_cnt_X <= grant_cnt_X + 1 (wraps at 2^CNT_W).
  - prio <= other(X).
- Latency: exactly 1 cycle from accept edge to out_valid.
- prio does not change on cycles without an accept.
- Round-robin fairness: a lone requester is served back-to-back every cycle, since the other side's ~valid term opens ready.
- No accept and out_valid & out_ready: out_valid <= 0; out_data and out_src hold their last value.
- Backpressure: out_valid=1 & out_ready=0 gives can_accept=0.
  - Both readies are low.
  - out_data and out_src are stable until the handshake.
  - Requesters must hold valid/data (AXI-style: valid must not drop before accept).
- Simultaneous drain and accept in the same cycle: the new result replaces the old one; out_valid stays 1.
- Reset mid-operation (reset asserted with out_valid=1 or requests pending): the result is discarded; the first grant after release goes to A.
- No X propagation: out_data updates only on accept.

Decomposition:
- Shared package/include: SRC_A=1'b0 and SRC_B=1'b1 constants; default WIDTH and CNT_W.
- One natural sub-module: rr_arbiter2.
  - Inputs: clk, reset, req[1:0], advance. Outputs: grant[1:0], prio state.
  - Owns the prio pointer and the ready/grant equations.
  - Top level owns the output register, adder mux and counters.

Test Plan:
1. Reset sequence: hold reset low 3 cycles with a_valid=b_valid=1 → out_valid=0, counters=0, a_ready=1 (empty register, prio=A), b_ready=0; release reset → first accept is A.
2. Lone A stream: a_data=0,1,2,3 on consecutive cycles with out_ready=1 → out_data=2,3,4,5 with out_src=0 one cycle after each accept; back-to-back out_valid, grant_cnt_a=4.
3. Contention: both valid continuously, a_data=10, b_data=100, out_ready=1 → results alternate 12(A), 105(B), 12, 105…; grant_cnt_a and grant_cnt_b differ by at most 1.
4. Backpressure: accept B with b_data=7, then out_ready=0 for 4 cycles while a_valid=1 → out_data=12 held, a_ready=b_ready=0; raising out_ready → A accepted the same cycle, next out_data=a_data+2 with no bubble.
5. Wrap-around: a_data=32'hFFFF_FFFF → out_data=32'h0000_0001; b_data=32'hFFFF_FFFC → 32'h0000_0001, out_src=1. Separately drive 65536 A grants → grant_cnt_a wraps to 0.
6. Reset mid-operation: assert reset while out_valid=1 and out_ready=0 → out_valid drops asynchronously (before next edge); after release with both valid → A granted first.

Source files
------------

// File: rtl/offset_add_arbiter_pkg.sv
// offset_add_arbiter_pkg: source tags and default widths shared by the offset-adder arbiter
package offset_add_arbiter_pkg;
    localparam logic SRC_A     = 1'b0;
    localparam logic SRC_B     = 1'b1;
    localparam int   DEF_WIDTH = 32;
    localparam int   DEF_CNT_W = 16;
endpackage

// File: rtl/offset_add_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin ready generation with a priority pointer
module rr_arbiter2
    import offset_add_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       prio
);
    // Readies never look at their own request: a lone requester always sees ready, a tie goes to prio
    always_comb begin
        grant[0] = advance & (~req[1] | prio == SRC_A);
        grant[1] = advance & (~req[0] | prio == SRC_B);
    end
    // Pointer moves to the other side only when a handshake completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prio <= SRC_A;
        else if (|(grant & req)) prio <= (grant[0] & req[0]) ? SRC_B : SRC_A;
    end
endmodule

// File: rtl/offset_add_arbiter.sv
// offset_add_arbiter: one registered offset adder shared round-robin between requesters A and B
module offset_add_arbiter
    import offset_add_arbiter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int OFFSET_A = 2,
    parameter int OFFSET_B = 5,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic [CNT_W-1:0] grant_cnt_a,
    output logic [CNT_W-1:0] grant_cnt_b
);
    logic             can_accept;
    logic [1:0]       grant;
    logic             prio;
    logic             acc_a;
    logic             acc_b;
    logic [WIDTH-1:0] sum;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     ({b_valid, a_valid}),
        .advance (can_accept),
        .grant   (grant),
        .prio    (prio)
    );

    // Output register is free when empty or being drained this cycle; winner's operand gets its offset
    always_comb begin
        can_accept = ~out_valid | out_ready;
        a_ready    = grant[0];
        b_ready    = grant[1];
        acc_a      = a_valid & a_ready;
        acc_b      = b_valid & b_ready;
        sum        = acc_a ? a_data + WIDTH'(OFFSET_A) : b_data + WIDTH'(OFFSET_B);
    end

    // Result register: loads on accept, otherwise empties on drain with data/src held
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= SRC_A;
        end else if (acc_a | acc_b) begin
            out_valid <= 1'b1;
            out_data  <= sum;
            out_src   <= acc_a ? SRC_A : SRC_B;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Per-requester accept counters, wrapping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt_a <= '0;
            grant_cnt_b <= '0;
        end else begin
            if (acc_a) grant_cnt_a <= grant_cnt_a + 1'b1;
            if (acc_b) grant_cnt_b <= grant_cnt_b + 1'b1;
        end
    end
endmodule

// File: tb/tb_offset_add_arbiter.sv
// tb_offset_add_arbiter: directed stimulus with a scoreboard queue checked by an output monitor
module tb_offset_add_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, out_valid, out_src;
    logic [31:0] out_data;
    logic [15:0] grant_cnt_a, grant_cnt_b;
    logic [32:0] expq[$];
    int          total = 0, bad = 0, cyc = 0;

    offset_add_arbiter dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_ready(out_ready),
        .grant_cnt_a(grant_cnt_a), .grant_cnt_b(grant_cnt_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake must match the oldest expected result
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got src=%0d data=%0h with empty scoreboard", out_src, out_data);
            end else begin
                chk("result", {31'd0, out_src, out_data}, {31'd0, expq.pop_front()});
            end
        end
    end

    task automatic push(input logic src, input logic [31:0] d);
        expq.push_back({src, d});
    endtask

    task automatic put_a(input logic [31:0] d);
        int n = 0;
        a_valid = 1'b1;
        a_data  = d;
        @(negedge clk);
        while (!a_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!a_ready) chk("a_accept_timeout", 0, 1);
        @(posedge clk);
        #1 a_valid = 1'b0;
    endtask

    task automatic put_b(input logic [31:0] d);
        int n = 0;
        b_valid = 1'b1;
        b_data  = d;
        @(negedge clk);
        while (!b_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!b_ready) chk("b_accept_timeout", 0, 1);
        @(posedge clk);
        #1 b_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("drain_empty", expq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        // Reset held with both requesting
        a_valid = 1'b1; b_valid = 1'b1; a_data = 32'd20; b_data = 32'd30;
        repeat (3) begin
            @(negedge clk);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_cnts", {grant_cnt_a, grant_cnt_b}, 0);
            chk("rst_ready", {a_ready, b_ready}, 2'b10);
        end
        chk("rst_out_data_src", {out_src, out_data}, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        push(0, 32'd22); push(1, 32'd35);
        fork put_a(32'd20); put_b(32'd30); join
        drain();
        // Lone A stream, back-to-back
        for (int i = 0; i < 4; i++) push(0, 32'(i + 2));
        c0 = cyc;
        for (int i = 0; i < 4; i++) put_a(32'(i));
        chk("a_stream_cycles", cyc - c0, 4);
        drain();
        chk("cnt_after_stream", {grant_cnt_a, grant_cnt_b}, {16'd5, 16'd1});
        // Contention: pointer sits at B after the A stream
        for (int i = 0; i < 3; i++) begin
            push(1, 32'd105);
            push(0, 32'd12);
        end
        fork
            repeat (3) put_a(32'd10);
            repeat (3) put_b(32'd100);
        join
        drain();
        chk("cnt_after_contention", {grant_cnt_a, grant_cnt_b}, {16'd8, 16'd4});
        // Backpressure: B result stalled, A waiting
        push(1, 32'd12); push(0, 32'd52);
        put_b(32'd7);
        out_ready = 1'b0; a_valid = 1'b1; a_data = 32'd50;
        repeat (4) begin
            @(negedge clk);
            chk("bp_ready", {a_ready, b_ready}, 0);
            chk("bp_hold", {out_valid, out_src, out_data}, {2'b11, 32'd12});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        put_a(32'd50);
        chk("bp_no_bubble", {out_valid, out_src, out_data}, {2'b10, 32'd52});
        drain();
        // Data wrap-around
        push(0, 32'h0000_0001); push(1, 32'h0000_0001);
        put_a(32'hFFFF_FFFF);
        put_b(32'hFFFF_FFFC);
        drain();
        // Counter wrap after a fresh reset
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            push(0, 32'(i + 2));
            put_a(32'(i));
        end
        chk("cnt_a_max", grant_cnt_a, 16'hFFFF);
        push(0, 32'd65537);
        put_a(32'd65535);
        chk("cnt_a_wrap", grant_cnt_a, 0);
        drain();
        // Reset mid-operation with a stalled result
        out_ready = 1'b0;
        put_a(32'd5);
        chk("mid_valid_before", out_valid, 1);
        #2 reset = 1'b0;
        #1 chk("mid_async_clear", {out_valid, grant_cnt_a}, 0);
        a_valid = 1'b1; b_valid = 1'b1; a_data = 32'd1; b_data = 32'd2; out_ready = 1'b1;
        push(0, 32'd3); push(1, 32'd7);
        @(posedge clk);
        #1 reset = 1'b1;
        fork put_a(32'd1); put_b(32'd2); join
        drain();
        chk("final_cnts", {grant_cnt_a, grant_cnt_b}, {16'd1, 16'd1});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
